// File: rtl/fifo_drain_arb_pkg.sv
// Shared constants for the FIFO drain arbiter: FSM encoding and default sizes.
package fifo_arb_pkg;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SERVE = 1'b1;

    localparam int N_DEF     = 4;
    localparam int WIDTH_DEF = 8;
    localparam int BURST_DEF = 4;
endpackage

// File: rtl/fifo_drain_arb_if.sv
// Read-port bundle between the arbiter, its FIFOs and the downstream consumer.
// master = arbiter side, slave = FIFO/consumer side.
interface fifo_drain_arb_if import fifo_arb_pkg::*; #(
    parameter int N     = N_DEF,
    parameter int WIDTH = WIDTH_DEF
);
    localparam int SW = $clog2(N);

    logic [N-1:0]       rempty;
    logic [N*WIDTH-1:0] rdata;
    logic [N-1:0]       rinc;
    logic [WIDTH-1:0]   out_data;
    logic [SW-1:0]      out_src;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    modport master (
        input  rempty, rdata, out_ready,
        output rinc, out_data, out_src, out_valid, busy
    );

    modport slave (
        output rempty, rdata, out_ready,
        input  rinc, out_data, out_src, out_valid, busy
    );
endinterface

// File: rtl/fifo_drain_arb_rr_pick.sv
// Round-robin picker: first asserted request strictly after 'last', mod N.
// The previous winner is checked last, so it only wins when nobody else asks.
module rr_pick #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] last_i,
    output logic          any_o,
    output logic [SW-1:0] idx_o
);
    logic [SW-1:0] cand;

    // Scan from the farthest candidate down so the nearest one after last wins.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int k = N; k >= 1; k--) begin
            cand = SW'((int'(last_i) + k) % N);
            if (req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end
endmodule

// File: rtl/fifo_drain_arb.sv
// Drains N FWFT FIFO read ports into one registered valid/ready output.
// IDLE arbitrates (one bubble per grant), SERVE pops up to BURST words from
// the granted FIFO, ending early if it runs dry.
module fifo_drain_arb import fifo_arb_pkg::*; #(
    parameter int N     = N_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int BURST = BURST_DEF
) (
    input  logic            rclk,
    input  logic            rrst,
    fifo_drain_arb_if.master bus
);
    localparam int SW = $clog2(N);
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    logic [0:0]       state_q, state_d;
    logic [SW-1:0]    g_q, g_d;
    logic [SW-1:0]    last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q;
    logic [SW-1:0]    src_q;
    logic             vld_q;

    logic [N-1:0]     req;
    logic             pick_any;
    logic [SW-1:0]    pick_idx;
    logic             pop;
    logic [N-1:0]     rinc;

    assign req = ~bus.rempty;

    rr_pick #(.N(N), .SW(SW)) u_pick (
        .req_i (req),
        .last_i(last_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    // A pop needs a granted non-empty FIFO and room in the output register
    // (empty, or being emptied this very cycle).
    assign pop = (state_q == ST_SERVE) && !bus.rempty[g_q] && (!vld_q || bus.out_ready);

    // Pop strobe goes only to the granted FIFO.
    always_comb begin
        rinc = '0;
        if (pop) rinc[g_q] = 1'b1;
    end

    // Arbitration and burst accounting.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (pick_any) begin
                g_d     = pick_idx;
                cnt_d   = '0;
                state_d = ST_SERVE;
            end
        end else if (bus.rempty[g_q]) begin
            last_d  = g_q;
            state_d = ST_IDLE;
        end else if (pop) begin
            if (cnt_q == CW'(BURST - 1)) begin
                last_d  = g_q;
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // FSM registers; last starts at N-1 so the first search begins at FIFO 0.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            last_q  <= SW'(N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output register: load on pop, clear on accept without a refill.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            src_q  <= '0;
        end else if (pop) begin
            vld_q  <= 1'b1;
            data_q <= bus.rdata[g_q*WIDTH +: WIDTH];
            src_q  <= g_q;
        end else if (vld_q && bus.out_ready) begin
            vld_q  <= 1'b0;
        end
    end

    assign bus.rinc      = rinc;
    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;
    assign bus.out_valid = vld_q;
    assign bus.busy      = (state_q == ST_SERVE);
endmodule

// File: tb/tb_fifo_drain_arb.sv
// Directed bench for fifo_drain_arb: N=4, WIDTH=8, BURST=4.
// FIFO i is modelled by a load count and a pop count; its head word is
// {i, pop count[3:0]}, so every word identifies its source and sequence.
module tb_fifo_drain_arb;
    logic rclk = 1'b0;
    logic rrst = 1'b1;
    always #5 rclk = ~rclk;

    fifo_drain_arb_if #(.N(4), .WIDTH(8)) bus ();

    fifo_drain_arb #(.N(4), .WIDTH(8), .BURST(4)) dut (
        .rclk(rclk),
        .rrst(rrst),
        .bus (bus)
    );

    int loaded[4];
    int popped[4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bus.rempty[i]         = (loaded[i] == popped[i]);
            bus.rdata[i*8 +: 8]   = {4'(i), 4'(popped[i])};
        end
    end

    always @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            for (int i = 0; i < 4; i++) popped[i] <= 0;
        end else begin
            for (int i = 0; i < 4; i++) if (bus.rinc[i]) popped[i] <= popped[i] + 1;
        end
    end

    typedef struct {
        bit         rdy;
        logic [3:0] rinc;
        bit         vld;
        logic [1:0] src;
        logic [7:0] data;
        bit         busy;
    } vec_t;

    vec_t tab[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(bit rdy, logic [3:0] ri, bit v, logic [1:0] s, logic [7:0] d, bit b);
        vec_t r;
        r.rdy = rdy; r.rinc = ri; r.vld = v; r.src = s; r.data = d; r.busy = b;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge, drive ready, settle, check protocol rules.
    task automatic sample(bit rdy);
        @(negedge rclk);
        bus.out_ready = rdy;
        #1;
        chk("rinc_while_empty", 32'(bus.rinc & bus.rempty), 0);
        chk("rinc_while_stalled", 32'(bus.out_valid && !bus.out_ready && (bus.rinc != 0)), 0);
    endtask

    task automatic do_reset(int l0, int l1, int l2, int l3);
        @(negedge rclk);
        rrst = 1'b1;
        bus.out_ready = 1'b1;
        loaded[0] = l0; loaded[1] = l1; loaded[2] = l2; loaded[3] = l3;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_out_src", 32'(bus.out_src), 0);
        chk("rst_rinc", 32'(bus.rinc), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        @(negedge rclk);
        rrst = 1'b0;
    endtask

    task automatic run_seg(string name, int first, int len);
        for (int i = first; i < first + len; i++) begin
            sample(tab[i].rdy);
            chk({name, "_rinc"}, 32'(bus.rinc), 32'(tab[i].rinc));
            chk({name, "_valid"}, 32'(bus.out_valid), 32'(tab[i].vld));
            chk({name, "_busy"}, 32'(bus.busy), 32'(tab[i].busy));
            if (tab[i].vld) begin
                chk({name, "_src"}, 32'(bus.out_src), 32'(tab[i].src));
                chk({name, "_data"}, 32'(bus.out_data), 32'(tab[i].data));
            end
        end
    endtask

    initial begin
        int seg_single, seg_bp, seg_early;
        int n, e, p, s, sq;
        int acc[4];
        int mx, mn;

        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) loaded[i] = 0;

        // Single FIFO 2 with 3 words.
        seg_single = tab.size();
        tab.push_back(mk(1, 4'b0100, 0, 0, 8'h00, 1));
        tab.push_back(mk(1, 4'b0100, 1, 2, 8'h20, 1));
        tab.push_back(mk(1, 4'b0100, 1, 2, 8'h21, 1));
        tab.push_back(mk(1, 4'b0000, 1, 2, 8'h22, 1));
        tab.push_back(mk(1, 4'b0000, 0, 0, 8'h00, 0));
        tab.push_back(mk(1, 4'b0000, 0, 0, 8'h00, 0));
        // Backpressure: FIFO 1 with 6 words, ready low 5 cycles mid-burst.
        seg_bp = tab.size();
        tab.push_back(mk(1, 4'b0010, 0, 0, 8'h00, 1));
        tab.push_back(mk(1, 4'b0010, 1, 1, 8'h10, 1));
        for (int i = 0; i < 5; i++) tab.push_back(mk(0, 4'b0000, 1, 1, 8'h11, 1));
        tab.push_back(mk(1, 4'b0010, 1, 1, 8'h11, 1));
        tab.push_back(mk(1, 4'b0010, 1, 1, 8'h12, 1));
        tab.push_back(mk(1, 4'b0000, 1, 1, 8'h13, 0));
        tab.push_back(mk(1, 4'b0010, 0, 0, 8'h00, 1));
        tab.push_back(mk(1, 4'b0010, 1, 1, 8'h14, 1));
        tab.push_back(mk(1, 4'b0000, 1, 1, 8'h15, 1));
        tab.push_back(mk(1, 4'b0000, 0, 0, 8'h00, 0));
        // Early empty: FIFO 1 has 2 words, FIFO 3 has 3.
        seg_early = tab.size();
        tab.push_back(mk(1, 4'b0010, 0, 0, 8'h00, 1));
        tab.push_back(mk(1, 4'b0010, 1, 1, 8'h10, 1));
        tab.push_back(mk(1, 4'b0000, 1, 1, 8'h11, 1));
        tab.push_back(mk(1, 4'b0000, 0, 0, 8'h00, 0));
        tab.push_back(mk(1, 4'b1000, 0, 0, 8'h00, 1));
        tab.push_back(mk(1, 4'b1000, 1, 3, 8'h30, 1));
        tab.push_back(mk(1, 4'b1000, 1, 3, 8'h31, 1));
        tab.push_back(mk(1, 4'b0000, 1, 3, 8'h32, 1));
        tab.push_back(mk(1, 4'b0000, 0, 0, 8'h00, 0));

        do_reset(0, 0, 3, 0);
        run_seg("single", seg_single, seg_bp - seg_single);
        do_reset(0, 6, 0, 0);
        run_seg("backpressure", seg_bp, seg_early - seg_bp);
        do_reset(0, 2, 0, 3);
        run_seg("early", seg_early, tab.size() - seg_early);

        // Round robin: groups of 4 words per source, one bubble between groups.
        do_reset(10, 10, 10, 10);
        for (e = 1; e <= 40; e++) begin
            sample(1);
            p = (e - 1) % 5;
            chk("rr_valid", 32'(bus.out_valid), 32'(p != 0));
            if (p != 0) begin
                s  = ((e - 1) / 5) % 4;
                sq = ((e - 1) / 20) * 4 + p - 1;
                chk("rr_src", 32'(bus.out_src), 32'(s));
                chk("rr_data", 32'(bus.out_data), 32'(s * 16 + sq));
            end
        end

        // Wrap: after a full burst on FIFO 3 (which still has data), FIFO 0 wins.
        do_reset(0, 0, 0, 5);
        sample(1);
        chk("wrap_first_grant", 32'(bus.rinc), 32'h8);
        loaded[0] = 2;
        n = 0;
        while (bus.busy && n < 10) begin
            sample(1);
            n++;
        end
        chk("wrap_burst_end", 32'(bus.busy), 0);
        sample(1);
        chk("wrap_rempty", 32'(bus.rempty), 32'h6);
        chk("wrap_grant", 32'(bus.rinc), 32'h1);

        // Asynchronous reset during a stall.
        do_reset(0, 0, 6, 0);
        sample(1);
        sample(0);
        chk("stall_valid", 32'(bus.out_valid), 1);
        sample(0);
        #2;
        rrst = 1'b1;
        loaded[1] = 3;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 0);
        chk("async_rst_rinc", 32'(bus.rinc), 0);
        chk("async_rst_busy", 32'(bus.busy), 0);
        @(negedge rclk);
        rrst = 1'b0;
        sample(1);
        chk("post_rst_grant", 32'(bus.rinc), 32'h2);

        // Fairness and no loss/duplication under random backpressure.
        do_reset(1000, 1000, 1000, 1000);
        for (int i = 0; i < 4; i++) acc[i] = 0;
        for (int c = 0; c < 1000; c++) begin
            sample($urandom_range(0, 3) != 0);
            if (bus.out_valid && bus.out_ready) begin
                s = int'(bus.out_src);
                chk("fair_data", 32'(bus.out_data), 32'(s * 16 + (acc[s] % 16)));
                acc[s]++;
            end
        end
        mx = acc[0]; mn = acc[0];
        for (int i = 1; i < 4; i++) begin
            if (acc[i] > mx) mx = acc[i];
            if (acc[i] < mn) mn = acc[i];
        end
        chk("fair_spread_le_burst", 32'(mx - mn <= 4), 1);
        chk("fair_progress", 32'(mn > 100), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_drain_arb.md
# fifo_drain_arb

Read-side scheduler that shares one downstream consumer among N asynchronous FIFOs. It sits in the read clock domain, directly on the read ports of the FIFOs (rempty, rinc, first-word-fall-through read data). Grants are round-robin with a burst limit per grant. Each word passes through a single registered output stage with a valid/ready handshake.

## Interface
- N, 4: number of FIFO read ports, ≥2.
- WIDTH, 8: data word width.
- BURST, 4: maximum words popped per grant, ≥1.

- rclk  in  1  read-domain clock; all logic rising-edge.
- rrst  in  1  reset, asynchronous, active-high.
- rempty  in  N  per-FIFO empty flag, pessimistic (may lag writes, never lags reads).
- rdata  in  N*WIDTH  FWFT read data; slice i = rdata[i*WIDTH +: WIDTH]; valid whenever rempty[i]=0.
- rinc  out  N  one-hot-or-zero pop strobe, combinational.
- out_data  out  WIDTH  registered word.
- out_src  out  $clog2(N)  index of the FIFO the word came from.
- out_valid  out  1  out_data/out_src valid.
- out_ready  in  1  consumer accepts when high with out_valid.
- busy  out  1  high in SERVE state.

## Operation
- FSM states: IDLE and SERVE. Registers: g (current grant), last (previous grant), cnt (0..BURST-1).
- IDLE:
  - rinc=0.
  - If any rempty[i]=0, pick the first non-empty index searching last+1, last+2, … (mod N). Load g with it, set cnt=0, go to SERVE.
  - Otherwise stay in IDLE.
- SERVE:
  - pop = !rempty[g] && (!out_valid || out_ready).
  - rinc[g] = pop; all other rinc bits are 0.
  - On pop: out_data<=rdata[g], out_src<=g, out_valid<=1.
  - On pop with cnt==BURST-1: last<=g, go to IDLE. Otherwise on pop: cnt<=cnt+1.
  - If rempty[g]=1: no pop, last<=g, go to IDLE. Burst ends early.
  - Stall (out_valid && !out_ready && !rempty[g]): no pop, hold cnt, stay in SERVE.
- Output stage: if out_valid && out_ready && !pop, then out_valid<=0. Pop and accept in the same cycle keeps out_valid=1 with the new word.
- Output stage runs independently of the FSM. A word can drain during IDLE.
- Index arithmetic is mod N. Wrap N-1→0 needs no special casing beyond the modulo.
- Reset values:
  - state=IDLE, g=0, last=N-1 (first search starts at 0), cnt=0.
  - out_valid=0, out_data=0, out_src=0, rinc=0, busy=0.
- Reset mid-burst drops the word held in the output register. Words already popped are lost. The FIFO pointers are owned by their own reset.

## Timing
- Non-empty flag sampled in IDLE at edge k → SERVE from k+1 → rinc during cycle k+1 → out_valid at edge k+2. Minimum latency is 2 cycles.
- Steady state with out_ready=1: one word per cycle, BURST words per grant.
- One IDLE (arbitration) bubble cycle between consecutive grants, including a re-grant of the same FIFO.
- rinc is never asserted while rempty of that FIFO is high. rinc is never asserted while out_valid && !out_ready.
- out_data, out_src and out_valid are stable while out_valid && !out_ready.

## Structure
- Shared package fifo_arb_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_SERVE=1'b1;
  - defaults for N, WIDTH, BURST.
- Sub-module rr_pick (combinational):
  - inputs: req[N], last index;
  - outputs: any, idx of the first request after last (mod N).
- The top level holds the FSM, counter and output register.

## Test plan
- Reset then single FIFO: only rempty[2]=0 with 3 words, out_ready=1 → rinc[2] pulses 3 times, out_src=2 for 3 consecutive out_valid cycles starting 2 cycles after release, then IDLE.
- Round-robin with burst: all 4 FIFOs hold 10 words, BURST=4 → out_src sequence 0×4, 1×4, 2×4, 3×4, 0×4…, with exactly one valid-low bubble between groups.
- Backpressure: out_ready=0 for 5 cycles mid-burst → out_valid stays 1, out_data held, rinc=0, cnt frozen; out_ready=1 → burst resumes with the remaining count and no word lost or duplicated.
- Early empty: FIFO 1 has 2 words, BURST=4, FIFO 3 non-empty → 2 words from src 1, IDLE, then src 3; rinc[1] never asserted while rempty[1]=1.
- Wrap and fairness: last=3, rempty=4'b0110 (FIFOs 0 and 3 non-empty) → next grant is 0, not 3; continuous load on all FIFOs for 1000 cycles gives per-source counts differing by at most BURST.
- Reset mid-operation: assert rrst asynchronously during a stall → out_valid and rinc drop immediately, not at the next edge; after release the first grant goes to the lowest-index non-empty FIFO.
